// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the execute stage and the load/store unit.
//   req_*  : one memory request (store/load select, funct3, byte address, store data)
//   resp_* : one response (extended load data, error flag)
// master = requester (execute stage / bench), slave = lsu_mem_ctrl.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-wide data memory.
// Sub-word stores are done as read-modify-write, loads are lane-selected and
// sign/zero-extended, and bad requests are answered with an error and no
// memory access.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake (slave side)
//   mem_we     : word write enable to data memory
//   mem_addr   : word-aligned byte address to data memory
//   mem_wdata  : full write word to data memory
//   mem_rdata  : combinational read data for mem_addr
module lsu_mem_ctrl #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_ctrl_if.slave      bus,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam int unsigned XLEN       = 32;
    localparam logic [XLEN-1:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              mem_we_q, mem_we_d;

    logic              req_err_c;
    logic [XLEN-1:0]   load_ext_c;
    logic [XLEN-1:0]   merged_c;

    // Request validity: illegal funct3, misalignment, or beyond the memory
    always_comb begin
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (bus.req_we) begin
            illegal = (bus.req_funct3 > 3'd2);
        end else begin
            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                      (bus.req_funct3 == 3'd7);
        end
        misaligned   = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
        out_of_range = (bus.req_addr >= ADDR_LIMIT);
        req_err_c    = illegal || misaligned || out_of_range;
    end

    // Load lane select and extension
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'd0:    load_ext_c = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    load_ext_c = {{16{ld_half[15]}}, ld_half};
            3'd2:    load_ext_c = mem_rdata;
            3'd4:    load_ext_c = {24'd0, ld_byte};
            3'd5:    load_ext_c = {16'd0, ld_half};
            default: load_ext_c = '0;
        endcase
    end

    // Sub-word store merge into the word currently in memory
    always_comb begin
        merged_c = mem_rdata;
        if (funct3_q == 3'd0) begin
            case (addr_q[1:0])
                2'd0:    merged_c[7:0]   = wdata_q[7:0];
                2'd1:    merged_c[15:8]  = wdata_q[7:0];
                2'd2:    merged_c[23:16] = wdata_q[7:0];
                default: merged_c[31:24] = wdata_q[7:0];
            endcase
        end else if (funct3_q == 3'd1) begin
            if (addr_q[1]) begin
                merged_c[31:16] = wdata_q[15:0];
            end else begin
                merged_c[15:0]  = wdata_q[15:0];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        mem_we_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct3_d    = bus.req_funct3;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    rdata_d     = '0;
                    err_d       = req_err_c;
                    req_ready_d = 1'b0;
                    if (req_err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3 == 3'd2) begin
                        state_d  = WRITE;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                rdata_d      = load_ext_c;
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            MERGE: begin
                wdata_d  = merged_c;
                state_d  = WRITE;
                mem_we_d = 1'b1;
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign mem_wdata      = wdata_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller sitting directly upstream of data_memory; the execute stage hands it one memory request at a time.
- data_memory has only a word-wide write enable, so this block performs sub-word stores (SB/SH) as read-modify-write, and extracts and sign/zero-extends load data (LB/LH/LW/LBU/LHU).
- It also detects misaligned, out-of-range and illegal requests and reports them as errors without touching memory.

Parameters:
MEM_SIZE, 1024, data memory depth in 32-bit words; byte addresses >= MEM_SIZE*4 are out of range.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept request
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32 funct3 width/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data (0 for stores/errors)
resp_err  output  1  misaligned / out-of-range / illegal funct3
mem_we  output  1  data_memory write enable
mem_addr  output  32  word-aligned byte address to data_memory
mem_wdata  output  32  full word to data_memory
mem_rdata  input  32  combinational read data for mem_addr

Behaviour:
- Reset: state=IDLE; all latched regs=0. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts immediately; no write is issued after rst_n falls.
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr, wdata.
  - Error check, evaluated in the acceptance cycle:
    - funct3 illegal: loads 3/6/7, stores >2.
    - Misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
    - Out of range: addr >= MEM_SIZE*4.
  - Error -> RESP with err=1, rdata=0.
  - Otherwise: load -> LOAD; SW -> WRITE; SB/SH -> MERGE.
- LOAD:
  - Capture mem_rdata.
  - Select the byte at addr[1:0] or the half at addr[1]; word as-is.
  - funct3 0/1 sign-extend; 4/5 zero-extend.
  - Store result to rdata_q -> RESP.
- MERGE:
  - Capture mem_rdata.
  - Replace byte lane addr[1:0] with wdata[7:0] (SB), or half lane addr[1] with wdata[15:0] (SH); other lanes keep the old value.
  - -> WRITE.
- WRITE: mem_we=1 for exactly one cycle; mem_wdata=merged word (SB/SH) or latched wdata (SW) -> RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_ready.
  - Handshake cycle (valid&ready) -> IDLE. A new request is accepted no earlier than the following cycle.
- mem_addr={addr_q[31:2],2'b00} in every state except reset. mem_we=0 outside WRITE.
- Latency from accept edge to resp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
- req_ready=0 in all states except IDLE; requests there are ignored, not queued.
- resp_ready held low keeps the block in RESP indefinitely with no memory activity.
- x0-style zero address is legal; address 0 byte access is valid.

Test Plan:
- Word 1=0x80FF7F01; LB addr 0x4 -> resp_rdata 0x00000001; LB addr 0x6 -> 0xFFFFFFFF; LBU addr 0x7 -> 0x00000080; LH addr 0x6 -> 0xFFFF80FF; LHU addr 0x6 -> 0x000080FF; resp_valid exactly 2 cycles after accept each time.
- Word 2=0x00000002; SB addr 0x9 wdata 0xAB -> single mem_we pulse, mem_wdata 0x0000AB02, mem_addr 0x8; resp_valid 3 cycles after accept, resp_err 0.
- SH addr 0xE wdata 0x1234BEEF -> word 3 becomes 0xBEEF0003; SW addr 0x10 wdata 0xDEADBEEF -> word 4=0xDEADBEEF, latency 2.
- LW addr 0x6, SH addr 0x3, SB addr 0x1000 (MEM_SIZE=1024), funct3=3 load -> each: resp_err 1, rdata 0, no mem_we pulse, latency 1.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid/resp_rdata stable, req_ready 0; request presented meanwhile is not accepted.
- Assert rst_n=0 during MERGE of an SB -> no mem_we pulse, memory unchanged; all outputs return to reset values asynchronously.
